e21_burst_grant_arbiter: RTL

- 3-way round-robin arbiter with burst lock, for multi-beat message channels on the E21 core-side interconnect.
- Sits directly upstream of the per-channel grant monitor. It produces the `grant` strobes, and the monitor checks that at most one strobe is high whenever reset is deasserted.
- Muxes the granted requester's beat onto a single valid/ready output.
- Holds the grant for the whole burst, from the first beat to the beat with `last` set.

---
 rtl/e21_arb_pkg.sv | 40 ++++
 rtl/e21_starve_ctr.sv | 29 ++
 rtl/e21_burst_grant_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/e21_arb_pkg.sv
// Shared types and helpers for the E21 burst grant arbiter: FSM state,
// round-robin pick and one-hot decode, sized for up to MAX_REQ requesters.
package e21_arb_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning upward from ptr+1, wrapping at n_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int n_req);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      cand = (int'(ptr) + off) % n_req;
      if (off <= n_req && !pick.found && req[cand[MAX_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = MAX_IDX_W'(cand);
      end
    end
    return pick;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/e21_starve_ctr.sv
// Per-requester wait counter: saturates at LIMIT, clears when the requester's
// beat fires. Only instantiated when E21_ARB_STARVE_GUARD_EN is defined.
module e21_starve_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starve
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && r_count != CNT_W'(LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_starve = (r_count == CNT_W'(LIMIT));

endmodule

// File: rtl/e21_burst_grant_arbiter.sv
// Round-robin arbiter with burst lock muxing N_REQ beat streams onto one
// valid/ready output. Optional starvation override: E21_ARB_STARVE_GUARD_EN.
module e21_burst_grant_arbiter
  import e21_arb_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           in_valid,
  output logic [N_REQ-1:0]           in_ready,
  input  logic [N_REQ-1:0]           in_last,
  input  logic [N_REQ*DATA_W-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           starve
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_lock_idx;
  logic [IDX_W-1:0]    r_rr_ptr;

  rr_pick_t            w_pick;
  logic                w_any;
  logic [IDX_W-1:0]    w_idx;
  logic [MAX_REQ-1:0]  w_oh;
  logic                w_fire;
  logic                w_unused;
`ifdef E21_ARB_STARVE_GUARD_EN
  logic [N_REQ-1:0]    w_starve;
  logic [N_REQ-1:0]    w_starve_valid;
`endif

  // Grant selection: locked index in BURST, otherwise round-robin (or the
  // lowest starved valid requester). Reset gates everything combinationally.
  always_comb begin
    w_pick = rr_pick(MAX_REQ'(in_valid), MAX_IDX_W'(r_rr_ptr), N_REQ);
    w_any  = 1'b0;
    w_idx  = '0;
`ifdef E21_ARB_STARVE_GUARD_EN
    w_starve_valid = in_valid & w_starve;
`endif
    if (reset_n) begin
      if (r_state == BURST) begin
        w_any = 1'b1;
        w_idx = r_lock_idx;
      end else begin
        w_any = w_pick.found;
        w_idx = IDX_W'(w_pick.idx);
`ifdef E21_ARB_STARVE_GUARD_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (w_starve_valid[i]) begin
            w_any = 1'b1;
            w_idx = IDX_W'(i);
          end
        end
`endif
      end
    end
  end

  assign w_oh     = onehot(MAX_IDX_W'(w_idx));
  assign grant    = w_any ? w_oh[N_REQ-1:0] : '0;
  assign w_unused = ^{w_pick, w_oh};

  // Handshake: a beat transfers on a cycle where out_valid & out_ready; only
  // the granted requester sees in_ready, and it is out_ready passed through.
  assign in_ready  = grant & {N_REQ{out_ready}};
  assign out_valid = |(grant & in_valid);
  assign out_last  = |(grant & in_last);
  assign out_src   = w_any ? w_idx : '0;
  assign w_fire    = out_valid & out_ready;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) out_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= IDX_W'(N_REQ - 1);
      r_lock_idx <= '0;
    end else if (w_fire) begin
      case (r_state)
        IDLE: begin
          if (out_last) begin
            r_rr_ptr <= w_idx;
          end else begin
            r_state    <= BURST;
            r_lock_idx <= w_idx;
          end
        end
        BURST: begin
          if (out_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_lock_idx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef E21_ARB_STARVE_GUARD_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_starve
    e21_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .i_inc   (in_valid[g] & ~in_ready[g]),
      .i_clr   (w_fire & grant[g]),
      .o_starve(w_starve[g])
    );
  end
  assign starve = w_starve;
`else
  assign starve = {N_REQ{1'b0 & (STARVE_LIMIT > 0)}};
`endif

endmodule
